// File: rtl/seg_pkg.sv
// Shared constants, page-mode type and active-low hex font
// for the board's 8-digit 7-segment display.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } page_state_t;

    // Cathode pattern {g,f,e,d,c,b,a}, 0 = segment lit.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0: code = 7'h40;
            4'h1: code = 7'h79;
            4'h2: code = 7'h24;
            4'h3: code = 7'h30;
            4'h4: code = 7'h19;
            4'h5: code = 7'h12;
            4'h6: code = 7'h02;
            4'h7: code = 7'h78;
            4'h8: code = 7'h00;
            4'h9: code = 7'h10;
            4'hA: code = 7'h08;
            4'hB: code = 7'h03;
            4'hC: code = 7'h46;
            4'hD: code = 7'h21;
            4'hE: code = 7'h06;
            default: code = 7'h0E;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to active-low 7-segment code.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex7(nibble);
    end

endmodule

// File: rtl/seg_display_sched.sv
// Snapshot capture, page selection (manual/auto) and digit scanning
// for the shared 8-digit 7-segment display.
module seg_display_sched
    import seg_pkg::*;
#(
    parameter int NUM_SRC  = 3,
    parameter int SCAN_DIV = 25000,
    parameter int PAGE_DIV = 50000000,
    localparam int PAGE_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [32*NUM_SRC-1:0]   src_data,
    input  logic [NUM_SRC-1:0]      src_valid,
    input  logic                    freeze,
    input  logic                    auto_en,
    input  logic                    btn_next,
    output logic [PAGE_W-1:0]       page,
    output logic [6:0]              SEG,
    output logic [7:0]              AN
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int PCNT_W = (PAGE_DIV > 1) ? $clog2(PAGE_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [PCNT_W-1:0] PAGE_LAST = PCNT_W'(PAGE_DIV - 1);
    localparam logic [PAGE_W-1:0] PAGE_MAX  = PAGE_W'(NUM_SRC - 1);

    if (NUM_SRC < 1 || NUM_SRC > 8) begin : g_bad_num_src
        $error("seg_display_sched: NUM_SRC must be in 1..8");
    end
    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("seg_display_sched: SCAN_DIV must be >= 2");
    end
    if (PAGE_DIV < 2) begin : g_bad_page_div
        $error("seg_display_sched: PAGE_DIV must be >= 2");
    end

    logic [31:0]       snap_reg [NUM_SRC];
    logic [SCAN_W-1:0] scan_cnt_reg;
    logic [2:0]        digit_reg;
    logic [PCNT_W-1:0] page_cnt_reg;
    logic [PAGE_W-1:0] page_reg;
    page_state_t       state_reg;
    logic [6:0]        seg_reg;
    logic [7:0]        an_reg;

    logic [31:0]       page_word;
    logic [3:0]        nib [8];
    logic [3:0]        cur_nib;
    logic [6:0]        seg_code;
    logic [PAGE_W-1:0] page_adv;
    page_state_t       state_next;

    // Snapshot registers
    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                snap_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_valid[i] && !freeze) begin
                    snap_reg[i] <= src_data[32*i +: 32];
                end
            end
        end
    end

    // Mux by comparison so a page value beyond NUM_SRC-1 can never index out of range.
    always_comb begin
        page_word = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (page_reg == PAGE_W'(i)) begin
                page_word = snap_reg[i];
            end
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_nib
        assign nib[gi] = page_word[4*gi +: 4];
    end

    assign cur_nib = nib[digit_reg];

    seg_hex_decode u_hex_decode (
        .nibble (cur_nib),
        .seg    (seg_code)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            scan_cnt_reg <= '0;
            digit_reg    <= '0;
        end else if (scan_cnt_reg == SCAN_LAST) begin
            scan_cnt_reg <= '0;
            digit_reg    <= digit_reg + 3'd1;
        end else begin
            scan_cnt_reg <= scan_cnt_reg + SCAN_W'(1);
        end
    end

    // First cycle of every slot is dark so the previous digit does not ghost.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            seg_reg <= SEG_BLANK;
            an_reg  <= AN_OFF;
        end else if (scan_cnt_reg == '0) begin
            seg_reg <= SEG_BLANK;
            an_reg  <= AN_OFF;
        end else begin
            seg_reg <= seg_code;
            an_reg  <= ~(8'b1 << digit_reg);
        end
    end

    assign page_adv   = (page_reg == PAGE_MAX) ? '0 : page_reg + PAGE_W'(1);
    assign state_next = auto_en ? AUTO : MANUAL;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg    <= MANUAL;
            page_reg     <= '0;
            page_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg) begin
                page_cnt_reg <= '0;
            end else begin
                case (state_reg)
                    MANUAL: begin
                        page_cnt_reg <= '0;
                        if (btn_next) begin
                            page_reg <= page_adv;
                        end
                    end
                    AUTO: begin
                        // A button press on the terminal count still yields a single advance.
                        if (btn_next || page_cnt_reg == PAGE_LAST) begin
                            page_reg     <= page_adv;
                            page_cnt_reg <= '0;
                        end else begin
                            page_cnt_reg <= page_cnt_reg + PCNT_W'(1);
                        end
                    end
                    default: page_cnt_reg <= '0;
                endcase
            end
        end
    end

    assign page = page_reg;
    assign SEG  = seg_reg;
    assign AN   = an_reg;

endmodule

// File: tb/tb_seg_display_sched.sv
// Randomised and directed bench for seg_display_sched against a cycle-count based model.
module tb_seg_display_sched;

    localparam int NUM_SRC  = 3;
    localparam int SCAN_DIV = 4;
    localparam int PAGE_DIV = 10;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [95:0] src_data;
    logic [2:0]  src_valid;
    logic        freeze;
    logic        auto_en;
    logic        btn_next;
    logic [1:0]  page;
    logic [6:0]  SEG;
    logic [7:0]  AN;

    always #5 CLK = ~CLK;

    seg_display_sched #(
        .NUM_SRC  (NUM_SRC),
        .SCAN_DIV (SCAN_DIV),
        .PAGE_DIV (PAGE_DIV)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .src_data  (src_data),
        .src_valid (src_valid),
        .freeze    (freeze),
        .auto_en   (auto_en),
        .btn_next  (btn_next),
        .page      (page),
        .SEG       (SEG),
        .AN        (AN)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model: scan position derives from cycles since reset release.
    logic [31:0] m_snap [NUM_SRC];
    int          m_page;
    int          m_cnt;
    bit          m_auto;
    int          m_t;
    bit          model_ok = 1'b0;
    logic [6:0]  exp_seg;
    logic [7:0]  exp_an;
    int          exp_page;

    always @(posedge CLK) begin : model
        int         slot_pos;
        int         dig;
        logic [31:0] w;
        logic [3:0]  nb;
        if (!RST) begin
            for (int i = 0; i < NUM_SRC; i++) m_snap[i] = '0;
            m_page = 0; m_cnt = 0; m_auto = 1'b0; m_t = 0;
            exp_seg = 7'h7F; exp_an = 8'hFF; exp_page = 0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            slot_pos = m_t % SCAN_DIV;
            dig      = (m_t / SCAN_DIV) % 8;
            w        = m_snap[m_page];
            nb       = w[4*dig +: 4];
            exp_an   = (slot_pos == 0) ? 8'hFF : ~(8'(1) << dig);
            exp_seg  = (slot_pos == 0) ? 7'h7F : hex_tab[nb];
            for (int i = 0; i < NUM_SRC; i++)
                if (src_valid[i] && !freeze) m_snap[i] = src_data[32*i +: 32];
            if (auto_en != m_auto) begin
                m_auto = auto_en;
                m_cnt  = 0;
            end else if (m_auto) begin
                if (btn_next || m_cnt == PAGE_DIV - 1) begin
                    m_page = (m_page + 1) % NUM_SRC;
                    m_cnt  = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else if (btn_next) begin
                m_page = (m_page + 1) % NUM_SRC;
            end
            m_t = m_t + 1;
            exp_page = m_page;
        end
    end

    always @(negedge CLK) begin
        if (model_ok) begin
            n_tests++;
            if (SEG !== exp_seg || AN !== exp_an || page !== 2'(exp_page)) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t SEG=%h AN=%h page=%0d expected SEG=%h AN=%h page=%0d",
                         $time, SEG, AN, page, exp_seg, exp_an, exp_page);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    task automatic wait_an(input logic [7:0] v);
        int k;
        k = 0;
        @(negedge CLK);
        while (AN !== v && k < 200) begin
            @(negedge CLK);
            k++;
        end
        check($sformatf("wait_an_%h", v), {24'h0, AN}, {24'h0, v});
    endtask

    task automatic wait_page_change(output int cycles);
        logic [1:0] prev;
        prev   = page;
        cycles = 0;
        do begin
            @(negedge CLK);
            cycles++;
        end while (page === prev && cycles < 100);
        check("page_change_bound", {31'h0, cycles < 100}, 32'h1);
    endtask

    task automatic press_btn;
        btn_next = 1'b1;
        @(negedge CLK);
        btn_next = 1'b0;
    endtask

    initial begin
        int cyc;
        int k;
        int exp_pages [3] = '{1, 2, 0};
        logic [1:0] prev;
        src_data = '0; src_valid = '0; freeze = 1'b0;
        auto_en = 1'b0; btn_next = 1'b0; RST = 1'b0;

        // Reset
        repeat (3) @(negedge CLK);
        check("rst_seg", {25'h0, SEG}, 32'h7F);
        check("rst_an", {24'h0, AN}, 32'hFF);
        check("rst_page", {30'h0, page}, 32'h0);
        RST = 1'b1;
        k = 0;
        do begin @(negedge CLK); k++; end while (AN === 8'hFF && k < 20);
        check("first_lit_an", {24'h0, AN}, 32'hFE);

        // Scan of a known word
        src_data[31:0] = 32'h0000_00A8; src_valid = 3'b001;
        @(negedge CLK);
        src_valid = 3'b000;
        wait_an(8'h7F);
        wait_an(8'hFE); check("scan_d0", {25'h0, SEG}, 32'h00);
        wait_an(8'hFD); check("scan_d1", {25'h0, SEG}, 32'h08);
        wait_an(8'hFB); check("scan_d2", {25'h0, SEG}, 32'h40);

        // Freeze blocks capture
        freeze = 1'b1; src_data[31:0] = 32'hFFFF_FFFF; src_valid = 3'b001;
        @(negedge CLK);
        src_valid = 3'b000;
        wait_an(8'h7F);
        wait_an(8'hFE); check("frz_d0", {25'h0, SEG}, 32'h00);
        wait_an(8'hF7); check("frz_d3", {25'h0, SEG}, 32'h40);
        freeze = 1'b0; src_valid = 3'b001;
        @(negedge CLK);
        src_valid = 3'b000;
        wait_an(8'h7F);
        wait_an(8'hFE); check("unfrz_d0", {25'h0, SEG}, 32'h0E);

        // Manual paging
        src_data[63:32] = 32'h1111_1111; src_data[95:64] = 32'h2222_2222; src_valid = 3'b110;
        @(negedge CLK);
        src_valid = 3'b000;
        for (int i = 0; i < 3; i++) begin
            press_btn();
            check($sformatf("manual_page%0d", i), {30'h0, page}, exp_pages[i]);
        end
        press_btn();
        wait_an(8'hFE); check("page1_seg", {25'h0, SEG}, 32'h79);
        press_btn();
        wait_an(8'hFE); check("page2_seg", {25'h0, SEG}, 32'h24);
        press_btn();
        check("manual_wrap", {30'h0, page}, 32'h0);

        // Auto rotation
        auto_en = 1'b1;
        wait_page_change(cyc);
        wait_page_change(cyc);
        check("auto_interval", cyc, 32'd10);
        repeat (9) @(negedge CLK);
        prev = page;
        press_btn();
        check("btn_on_terminal", {30'h0, page}, (prev == 2'd2) ? 32'd0 : {30'h0, prev} + 32'd1);
        wait_page_change(cyc);
        check("after_coincide", cyc, 32'd10);
        auto_en = 1'b0;
        @(negedge CLK);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) if (page !== 2'd2) press_btn();
        check("pre_rst_page", {30'h0, page}, 32'h2);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("mid_rst_page", {30'h0, page}, 32'h0);
        check("mid_rst_seg", {25'h0, SEG}, 32'h7F);
        check("mid_rst_an", {24'h0, AN}, 32'hFF);
        RST = 1'b1;
        k = 0;
        do begin @(negedge CLK); k++; end while (AN === 8'hFF && k < 20);
        check("post_rst_an", {24'h0, AN}, 32'hFE);
        check("post_rst_snap", {25'h0, SEG}, 32'h40);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            src_data  = {$urandom, $urandom, $urandom};
            src_valid = 3'($urandom) & 3'($urandom);
            freeze    = ($urandom % 4) == 0;
            btn_next  = 1'b0;
            if ($urandom % 150 == 0) auto_en = ~auto_en;
            else btn_next = ($urandom % 12) == 0;
            RST = ($urandom % 400) != 0;
            @(negedge CLK);
        end
        RST = 1'b1; src_valid = '0; btn_next = 1'b0;
        @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
